// File: rtl/cpu_run_controller.sv
// Run sequencer for the single-cycle core: loads a length-prefixed program from the host,
// runs it under a watchdog, then streams a fixed data-memory window back to the host.
module cpu_run_controller #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
  parameter int          DUMP_BYTES = 64,
  parameter int          MAX_CYCLES = 1000000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        PC_data_valid,
  input  logic [7:0]  PC_data,
  input  logic        SYS_start_button,
  input  logic        CPU_halt,
  input  logic        transmitter_buffer_full,
  input  logic [7:0]  DMEM_dump_data,
  output logic        IMEM_write_enable,
  output logic [31:0] IMEM_write_address,
  output logic [31:0] IMEM_write_data,
  output logic        CPU_reset,
  output logic        execution_enable,
  output logic [31:0] DMEM_dump_address,
  output logic        DMEM_transmit_request,
  output logic [7:0]  DMEM_data_transmit,
  output logic        load_error,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic [2:0]  ctrl_state
);

  localparam int IDX_W  = $clog2(IMEM_WORDS) + 1;
  localparam int DCNT_W = $clog2(DUMP_BYTES + 1);
  localparam logic [31:0]       IMEM_WORDS_L = 32'(IMEM_WORDS);
  localparam logic [31:0]       WDOG_LAST    = 32'(MAX_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DUMP_LAST    = DCNT_W'(DUMP_BYTES - 1);

  typedef enum logic [2:0] {
    S_LEN        = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_RUN        = 3'd3,
    S_DUMP       = 3'd4,
    S_DONE       = 3'd5,
    S_ERROR      = 3'd6
  } state_e;

  state_e            state_q;
  logic [1:0]        bcnt_q;
  logic [23:0]       asm_q;
  logic [IDX_W-1:0]  len_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DCNT_W-1:0] sent_q;
  logic              start_prev_q;
  logic              imem_we_q;
  logic [31:0]       imem_addr_q;
  logic [31:0]       imem_data_q;
  logic              cpu_reset_q;
  logic              exec_q;
  logic [31:0]       dump_addr_q;
  logic              tx_req_q;
  logic [7:0]        tx_data_q;
  logic              load_error_q;
  logic              timeout_q;
  logic [31:0]       cycle_q;

  logic        start_edge;
  logic [31:0] word_d;
  logic [31:0] cycle_d;

  // Bytes shift in from the top, so after three bytes asm_q holds {b2,b1,b0}.
  assign start_edge = SYS_start_button & ~start_prev_q;
  assign word_d     = {PC_data, asm_q};
  assign cycle_d    = cycle_q + 32'd1;

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q      <= S_LEN;
      bcnt_q       <= '0;
      asm_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      sent_q       <= '0;
      start_prev_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      cpu_reset_q  <= 1'b0;
      exec_q       <= 1'b0;
      dump_addr_q  <= DUMP_BASE;
      tx_req_q     <= 1'b0;
      tx_data_q    <= '0;
      load_error_q <= 1'b0;
      timeout_q    <= 1'b0;
      cycle_q      <= '0;
    end else begin
      start_prev_q <= SYS_start_button;
      imem_we_q    <= 1'b0;
      cpu_reset_q  <= 1'b0;
      tx_req_q     <= 1'b0;
      case (state_q)
        S_LEN: begin
          if (PC_data_valid) begin
            asm_q  <= {PC_data, asm_q[23:8]};
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              if (word_d == 32'd0) begin
                state_q <= S_WAIT_START;
              end else if (word_d > IMEM_WORDS_L) begin
                state_q      <= S_ERROR;
                load_error_q <= 1'b1;
              end else begin
                state_q <= S_LOAD;
                len_q   <= word_d[IDX_W-1:0];
                idx_q   <= '0;
              end
            end
          end
        end
        S_LOAD: begin
          if (PC_data_valid) begin
            asm_q  <= {PC_data, asm_q[23:8]};
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              imem_we_q   <= 1'b1;
              imem_data_q <= word_d;
              imem_addr_q <= {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
              idx_q       <= idx_q + IDX_W'(1);
              if (idx_q == len_q - IDX_W'(1)) state_q <= S_WAIT_START;
            end
          end
        end
        S_WAIT_START, S_DONE: begin
          if (start_edge) begin
            state_q     <= S_RUN;
            cpu_reset_q <= 1'b1;
            cycle_q     <= '0;
            timeout_q   <= 1'b0;
          end
        end
        S_RUN: begin
          // The first RUN cycle is the core reset cycle; execution starts after it.
          if (!exec_q) begin
            exec_q <= 1'b1;
          end else begin
            cycle_q <= cycle_d;
            if (CPU_halt || cycle_d == WDOG_LAST) begin
              state_q     <= S_DUMP;
              exec_q      <= 1'b0;
              dump_addr_q <= DUMP_BASE;
              sent_q      <= '0;
              timeout_q   <= ~CPU_halt;
            end
          end
        end
        S_DUMP: begin
          // A request cycle is always followed by an idle cycle so TX sees full in time.
          if (!transmitter_buffer_full && !tx_req_q) begin
            tx_data_q   <= DMEM_dump_data;
            tx_req_q    <= 1'b1;
            dump_addr_q <= dump_addr_q + 32'd1;
            sent_q      <= sent_q + DCNT_W'(1);
            if (sent_q == DUMP_LAST) state_q <= S_DONE;
          end
        end
        S_ERROR: begin
          state_q <= S_ERROR;
        end
        default: begin
          state_q <= S_ERROR;
        end
      endcase
    end
  end

  assign IMEM_write_enable     = imem_we_q;
  assign IMEM_write_address    = imem_addr_q;
  assign IMEM_write_data       = imem_data_q;
  assign CPU_reset             = cpu_reset_q;
  assign execution_enable      = exec_q;
  assign DMEM_dump_address     = dump_addr_q;
  assign DMEM_transmit_request = tx_req_q;
  assign DMEM_data_transmit    = tx_data_q;
  assign load_error            = load_error_q;
  assign timeout               = timeout_q;
  assign cycle_count           = cycle_q;
  assign ctrl_state            = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: load, run/halt, watchdog, dump back-pressure,
// mid-load reset and oversize-length error.
module tb_cpu_run_controller;

  localparam int          IMEM_WORDS = 256;
  localparam logic [31:0] DUMP_BASE  = 32'h0000_0010;
  localparam int          DUMP_BYTES = 4;
  localparam int          MAX_CYCLES = 16;

  logic        clk;
  logic        SYS_reset;
  logic        PC_data_valid;
  logic [7:0]  PC_data;
  logic        SYS_start_button;
  logic        CPU_halt;
  logic        transmitter_buffer_full;
  logic [7:0]  DMEM_dump_data;
  logic        IMEM_write_enable;
  logic [31:0] IMEM_write_address;
  logic [31:0] IMEM_write_data;
  logic        CPU_reset;
  logic        execution_enable;
  logic [31:0] DMEM_dump_address;
  logic        DMEM_transmit_request;
  logic [7:0]  DMEM_data_transmit;
  logic        load_error;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [2:0]  ctrl_state;

  cpu_run_controller #(
    .IMEM_WORDS(IMEM_WORDS), .DUMP_BASE(DUMP_BASE),
    .DUMP_BYTES(DUMP_BYTES), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .SYS_clk(clk), .SYS_reset(SYS_reset),
    .PC_data_valid(PC_data_valid), .PC_data(PC_data),
    .SYS_start_button(SYS_start_button), .CPU_halt(CPU_halt),
    .transmitter_buffer_full(transmitter_buffer_full), .DMEM_dump_data(DMEM_dump_data),
    .IMEM_write_enable(IMEM_write_enable), .IMEM_write_address(IMEM_write_address),
    .IMEM_write_data(IMEM_write_data), .CPU_reset(CPU_reset),
    .execution_enable(execution_enable), .DMEM_dump_address(DMEM_dump_address),
    .DMEM_transmit_request(DMEM_transmit_request), .DMEM_data_transmit(DMEM_data_transmit),
    .load_error(load_error), .timeout(timeout), .cycle_count(cycle_count),
    .ctrl_state(ctrl_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dmem [0:255];
  assign DMEM_dump_data = dmem[DMEM_dump_address[7:0]];

  int test_cnt = 0;
  int fail_cnt = 0;
  int wr_cnt   = 0;
  int tx_cnt   = 0;
  int exec_cnt = 0;
  int rst_cnt  = 0;
  logic full_prev = 1'b0;
  logic req_prev  = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_tx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: IMEM writes and TX bytes compared against expected queues.
  always @(posedge clk) full_prev <= transmitter_buffer_full;

  always @(negedge clk) begin
    if (IMEM_write_enable) begin
      wr_cnt++;
      check("imem_wr_expected", 32'(exp_addr_q.size() > 0), 32'd1);
      if (exp_addr_q.size() > 0) begin
        check("imem_wr_addr", IMEM_write_address, exp_addr_q.pop_front());
        check("imem_wr_data", IMEM_write_data, exp_data_q.pop_front());
      end
    end
    if (DMEM_transmit_request) begin
      tx_cnt++;
      check("tx_expected", 32'(exp_tx_q.size() > 0), 32'd1);
      if (exp_tx_q.size() > 0) check("tx_byte", 32'(DMEM_data_transmit), 32'(exp_tx_q.pop_front()));
      check("tx_not_back_to_back", 32'(req_prev), 32'd0);
      check("tx_not_while_full", 32'(full_prev), 32'd0);
    end
    req_prev = DMEM_transmit_request;
    if (execution_enable) exec_cnt++;
    if (CPU_reset) rst_cnt++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    SYS_reset = 1'b1;
    tick();
    SYS_reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    PC_data_valid = 1'b1;
    PC_data       = b;
    tick();
    PC_data_valid = 1'b0;
    tick();
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic press_start();
    SYS_start_button = 1'b0;
    tick();
    SYS_start_button = 1'b1;
    tick();
  endtask

  task automatic push_dump();
    exp_tx_q.push_back(8'h11);
    exp_tx_q.push_back(8'h22);
    exp_tx_q.push_back(8'h33);
    exp_tx_q.push_back(8'h44);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max_cycles);
    int n;
    n = 0;
    while (ctrl_state !== s && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 32'(ctrl_state), 32'(s));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(ctrl_state), 32'd0);
    check({tag, "_imem_we"}, 32'(IMEM_write_enable), 32'd0);
    check({tag, "_imem_addr"}, IMEM_write_address, 32'd0);
    check({tag, "_imem_data"}, IMEM_write_data, 32'd0);
    check({tag, "_cpu_reset"}, 32'(CPU_reset), 32'd0);
    check({tag, "_exec"}, 32'(execution_enable), 32'd0);
    check({tag, "_dump_addr"}, DMEM_dump_address, DUMP_BASE);
    check({tag, "_tx_req"}, 32'(DMEM_transmit_request), 32'd0);
    check({tag, "_tx_data"}, 32'(DMEM_data_transmit), 32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_cycle_count"}, cycle_count, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    SYS_reset = 1'b1;
    PC_data_valid = 1'b0;
    PC_data = 8'h00;
    SYS_start_button = 1'b0;
    CPU_halt = 1'b0;
    transmitter_buffer_full = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'(i) ^ 8'h5A;
    dmem[8'h10] = 8'h11;
    dmem[8'h11] = 8'h22;
    dmem[8'h12] = 8'h33;
    dmem[8'h13] = 8'h44;

    tick();
    tick();
    check_reset_outputs("reset");
    SYS_reset = 1'b0;

    // Length boundaries: 0 skips loading, 256 is still legal.
    send_len(32'd0);
    check("len0_state", 32'(ctrl_state), 32'd2);
    do_reset();
    send_len(32'd256);
    check("len256_state", 32'(ctrl_state), 32'd1);
    check("len256_no_error", 32'(load_error), 32'd0);
    do_reset();

    // Two-word program load.
    send_len(32'd2);
    check("load_state", 32'(ctrl_state), 32'd1);
    send_word(32'h0050_0013, 32'd0);
    check("load_mid_state", 32'(ctrl_state), 32'd1);
    send_word(32'h00A0_0093, 32'd4);
    check("load_done_state", 32'(ctrl_state), 32'd2);
    check("load_wr_cnt", 32'(wr_cnt), 32'd2);

    // Run, halt sampled in the 10th enabled cycle.
    exec_cnt = 0;
    rst_cnt  = 0;
    press_start();
    check("run_state", 32'(ctrl_state), 32'd3);
    check("run_cpu_reset", 32'(CPU_reset), 32'd1);
    check("run_exec_in_reset", 32'(execution_enable), 32'd0);
    check("run_cycle_start", cycle_count, 32'd0);
    repeat (10) tick();
    check("run_exec", 32'(execution_enable), 32'd1);
    check("run_cycle_9", cycle_count, 32'd9);
    CPU_halt = 1'b1;
    push_dump();
    tick();
    CPU_halt = 1'b0;
    check("halt_state", 32'(ctrl_state), 32'd4);
    check("halt_cycle_count", cycle_count, 32'd10);
    check("halt_timeout", 32'(timeout), 32'd0);
    check("halt_exec_off", 32'(execution_enable), 32'd0);
    check("halt_exec_cycles", 32'(exec_cnt), 32'd10);
    check("halt_cpu_reset_cycles", 32'(rst_cnt), 32'd1);
    check("dump_addr_base", DMEM_dump_address, DUMP_BASE);

    // Dump with back-pressure before the second byte.
    tx_cnt = 0;
    tick();
    check("dump_first_req", 32'(DMEM_transmit_request), 32'd1);
    check("dump_first_data", 32'(DMEM_data_transmit), 32'h11);
    transmitter_buffer_full = 1'b1;
    repeat (3) tick();
    check("dump_full_addr_held", DMEM_dump_address, DUMP_BASE + 32'd1);
    check("dump_full_data_held", 32'(DMEM_data_transmit), 32'h11);
    check("dump_full_tx_cnt", 32'(tx_cnt), 32'd1);
    transmitter_buffer_full = 1'b0;
    wait_state("dump_done_state", 3'd5, 20);
    check("dump_last_req", 32'(DMEM_transmit_request), 32'd1);
    check("dump_last_data", 32'(DMEM_data_transmit), 32'h44);
    check("dump_end_addr", DMEM_dump_address, DUMP_BASE + 32'd4);
    tick();
    check("done_req_low", 32'(DMEM_transmit_request), 32'd0);
    check("dump_tx_cnt", 32'(tx_cnt), 32'd4);
    check("dump_queue_empty", 32'(exp_tx_q.size()), 32'd0);

    // Watchdog: rerun from DONE with no halt.
    exec_cnt = 0;
    press_start();
    check("wdog_cycle_cleared", cycle_count, 32'd0);
    push_dump();
    wait_state("wdog_dump_state", 3'd4, 40);
    check("wdog_timeout", 32'(timeout), 32'd1);
    check("wdog_cycle_count", cycle_count, 32'd15);
    check("wdog_exec_cycles", 32'(exec_cnt), 32'd15);
    check("wdog_dump_addr", DMEM_dump_address, DUMP_BASE);
    wait_state("wdog_done_state", 3'd5, 20);

    // Halt coincident with the watchdog limit: halt wins.
    exec_cnt = 0;
    press_start();
    check("coinc_timeout_cleared", 32'(timeout), 32'd0);
    repeat (15) tick();
    check("coinc_still_run", 32'(ctrl_state), 32'd3);
    check("coinc_cycle_14", cycle_count, 32'd14);
    push_dump();
    CPU_halt = 1'b1;
    tick();
    CPU_halt = 1'b0;
    check("coinc_state", 32'(ctrl_state), 32'd4);
    check("coinc_timeout", 32'(timeout), 32'd0);
    check("coinc_cycle_count", cycle_count, 32'd15);
    check("coinc_exec_cycles", 32'(exec_cnt), 32'd15);
    wait_state("coinc_done_state", 3'd5, 20);

    // Reset in the middle of a word, with a byte arriving in the reset cycle.
    do_reset();
    wr_cnt = 0;
    send_len(32'd1);
    check("midload_state", 32'(ctrl_state), 32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    SYS_reset = 1'b1;
    PC_data_valid = 1'b1;
    PC_data = 8'hCC;
    tick();
    SYS_reset = 1'b0;
    PC_data_valid = 1'b0;
    check_reset_outputs("midload_reset");
    send_len(32'd1);
    check("midload_relen_state", 32'(ctrl_state), 32'd1);
    check("midload_no_write", 32'(wr_cnt), 32'd0);
    send_word(32'h1234_5678, 32'd0);
    check("midload_reload_state", 32'(ctrl_state), 32'd2);
    check("midload_wr_cnt", 32'(wr_cnt), 32'd1);

    // Oversize length goes to ERROR and stays there.
    do_reset();
    wr_cnt = 0;
    tx_cnt = 0;
    exec_cnt = 0;
    send_len(32'd300);
    check("err_state", 32'(ctrl_state), 32'd6);
    check("err_load_error", 32'(load_error), 32'd1);
    send_len(32'h0000_0001);
    press_start();
    repeat (5) tick();
    check("err_state_held", 32'(ctrl_state), 32'd6);
    check("err_no_writes", 32'(wr_cnt), 32'd0);
    check("err_no_tx", 32'(tx_cnt), 32'd0);
    check("err_no_exec", 32'(exec_cnt), 32'd0);
    check("err_sticky", 32'(load_error), 32'd1);
    do_reset();
    check("err_cleared", 32'(load_error), 32'd0);
    check("err_reset_state", 32'(ctrl_state), 32'd0);
    check("imem_queue_empty", 32'(exp_addr_q.size()), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
